// File: rtl/fb_arb_pkg.sv
// Shared definitions for the frame-buffer port arbiter: FSM state codes,
// owner codes, default widths and the arbitration decision function.
package fb_arb_pkg;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_MAX_WAIT   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_VGA = 1'b0,
        OWN_CPU = 1'b1
    } owner_e;

    // Pick the winner of one arbitration round. A lone requester always wins;
    // on contention the CPU wins only when starved or during blanking.
    function automatic owner_e pick_owner(
        input logic vga_req,
        input logic cpu_req,
        input logic vga_active,
        input logic starve_hit
    );
        owner_e win;
        if (vga_req && cpu_req) begin
            if (starve_hit || !vga_active) begin
                win = OWN_CPU;
            end else begin
                win = OWN_VGA;
            end
        end else if (cpu_req) begin
            win = OWN_CPU;
        end else begin
            win = OWN_VGA;
        end
        return win;
    endfunction

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Bundle of the VGA requester, CPU requester and RAM port signals.
// slave is the arbiter's view, master is the environment's view.
interface fb_port_arbiter_if #(
    parameter int ADDR_WIDTH = fb_arb_pkg::DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = fb_arb_pkg::DEF_DATA_WIDTH
);
    logic                  vga_active;
    logic                  vga_req;
    logic [ADDR_WIDTH-1:0] vga_addr;
    logic                  vga_ack;
    logic [DATA_WIDTH-1:0] vga_rdata;

    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_ack;
    logic [DATA_WIDTH-1:0] cpu_rdata;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  vga_active, vga_req, vga_addr,
        output vga_ack, vga_rdata,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata
    );

    modport master (
        output vga_active, vga_req, vga_addr,
        input  vga_ack, vga_rdata,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/fb_starve_timer.sv
// Saturating count of cycles the CPU has been kept waiting. hit tells the
// arbiter the CPU must win the next contended round.
module fb_starve_timer #(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic hit
);
    localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

    logic [7:0] wait_cnt_r;

    // Count waiting cycles up to MAX_CNT; clearing takes precedence
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt_r <= 8'd0;
        end else if (clr) begin
            wait_cnt_r <= 8'd0;
        end else if (inc && (wait_cnt_r != MAX_CNT)) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    assign hit = (wait_cnt_r == MAX_CNT);

endmodule

// File: rtl/fb_port_arbiter.sv
// Shares one synchronous-read RAM port between the VGA glyph fetch and the
// CPU. Every access is a fixed IDLE/ISSUE/WAIT/RESP sequence; arbitration
// happens only in IDLE and all RAM-facing and requester outputs are registered.
module fb_port_arbiter
    import fb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_WAIT   = DEF_MAX_WAIT
) (
    input  logic             clk,
    input  logic             reset,
    fb_port_arbiter_if.slave bus
);
    arb_state_e            state_r;
    arb_state_e            state_nxt_s;
    owner_e                owner_r;
    owner_e                grant_s;
    logic                  take_s;
    logic                  starve_hit_s;
    logic                  inc_s;
    logic                  clr_s;
    logic                  op_we_r;

    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [DATA_WIDTH-1:0] mem_wdata_r;
    logic                  mem_we_r;
    logic                  vga_ack_r;
    logic                  cpu_ack_r;
    logic [DATA_WIDTH-1:0] vga_rdata_r;
    logic [DATA_WIDTH-1:0] cpu_rdata_r;

    fb_starve_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_s),
        .clr   (clr_s),
        .hit   (starve_hit_s)
    );

    // Decide the winner and drive the starvation counter controls
    always_comb begin
        grant_s = pick_owner(bus.vga_req, bus.cpu_req, bus.vga_active, starve_hit_s);
        take_s  = 1'b0;
        inc_s   = 1'b0;
        clr_s   = 1'b0;
        if (state_r == ST_IDLE) begin
            take_s = bus.vga_req | bus.cpu_req;
        end else begin
            take_s = 1'b0;
        end
        // The CPU is not waiting while its own transaction is in flight
        if (bus.cpu_req && !((state_r != ST_IDLE) && (owner_r == OWN_CPU))) begin
            inc_s = 1'b1;
        end else begin
            inc_s = 1'b0;
        end
        if (!bus.cpu_req || (take_s && (grant_s == OWN_CPU))) begin
            clr_s = 1'b1;
        end else begin
            clr_s = 1'b0;
        end
    end

    // Next-state logic for the fixed four-cycle transaction
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (take_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nxt_s = ST_WAIT;
            ST_WAIT:  state_nxt_s = ST_RESP;
            ST_RESP:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Latch the winner's request onto the RAM port; the write strobe lasts one cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            owner_r     <= OWN_VGA;
            op_we_r     <= 1'b0;
            mem_addr_r  <= {ADDR_WIDTH{1'b0}};
            mem_wdata_r <= {DATA_WIDTH{1'b0}};
            mem_we_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (take_s) begin
                        owner_r <= grant_s;
                        if (grant_s == OWN_CPU) begin
                            mem_addr_r  <= bus.cpu_addr;
                            mem_wdata_r <= bus.cpu_wdata;
                            mem_we_r    <= bus.cpu_we;
                            op_we_r     <= bus.cpu_we;
                        end else begin
                            // VGA only reads; leave mem_wdata as it was
                            mem_addr_r  <= bus.vga_addr;
                            mem_we_r    <= 1'b0;
                            op_we_r     <= 1'b0;
                        end
                    end
                end
                ST_ISSUE: mem_we_r <= 1'b0;
                default: begin
                end
            endcase
        end
    end

    // Capture read data for the owner and pulse its ack for the RESP cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            vga_ack_r   <= 1'b0;
            cpu_ack_r   <= 1'b0;
            vga_rdata_r <= {DATA_WIDTH{1'b0}};
            cpu_rdata_r <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_WAIT: begin
                    if (owner_r == OWN_CPU) begin
                        cpu_ack_r <= 1'b1;
                        if (!op_we_r) begin
                            cpu_rdata_r <= bus.mem_rdata;
                        end
                    end else begin
                        vga_ack_r   <= 1'b1;
                        vga_rdata_r <= bus.mem_rdata;
                    end
                end
                ST_RESP: begin
                    vga_ack_r <= 1'b0;
                    cpu_ack_r <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.vga_ack   = vga_ack_r;
    assign bus.vga_rdata = vga_rdata_r;
    assign bus.cpu_ack   = cpu_ack_r;
    assign bus.cpu_rdata = cpu_rdata_r;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a small synchronous RAM model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fb_port_arbiter;
    import fb_arb_pkg::*;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    logic        ram_clr;
    logic        pre_en;
    logic [7:0]  pre_addr;
    logic [15:0] pre_data;
    logic [15:0] ram [0:255];
    logic [15:0] vpat;
    logic [15:0] cpat;

    fb_port_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

    fb_port_arbiter #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (16),
        .MAX_WAIT   (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Synchronous-read RAM, 256 words indexed by the low address byte
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) ram[i] <= 16'h0000;
        end
        if (pre_en) ram[pre_addr] <= pre_data;
        if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        vpat   = 16'h0000;
        cpat   = 16'h0000;
        reset  = 1'b0;
        ram_clr = 1'b1;
        pre_en  = 1'b0;
        pre_addr = 8'h50;
        pre_data = 16'h4142;
        bus.vga_active = 1'b1;
        bus.vga_req    = 1'b1;
        bus.vga_addr   = 16'h0010;
        bus.cpu_req    = 1'b1;
        bus.cpu_we     = 1'b1;
        bus.cpu_addr   = 16'h3000;
        bus.cpu_wdata  = 16'hBEEF;

        // Reset held three cycles with both requests high
        cyc(1);
        ram_clr = 1'b0;
        pre_en  = 1'b1;
        cyc(1);
        pre_en  = 1'b0;
        cyc(1);
        chk("rst_vga_ack",   32'(bus.vga_ack),   32'd0);
        chk("rst_cpu_ack",   32'(bus.cpu_ack),   32'd0);
        chk("rst_vga_rdata", 32'(bus.vga_rdata), 32'h0);
        chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'h0);
        chk("rst_mem_addr",  32'(bus.mem_addr),  32'h0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
        chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
        chk("rst_state",     32'(dut.state_r),   32'(ST_IDLE));
        reset = 1'b1;

        // First grant goes to VGA during active video
        cyc(1);
        chk("g1_mem_addr", 32'(bus.mem_addr), 32'h0010);
        chk("g1_mem_we",   32'(bus.mem_we),   32'd0);
        chk("g1_vga_ack_early", 32'(bus.vga_ack), 32'd0);
        cyc(2);
        chk("g1_vga_ack",   32'(bus.vga_ack),   32'd1);
        chk("g1_cpu_ack",   32'(bus.cpu_ack),   32'd0);
        chk("g1_vga_rdata", 32'(bus.vga_rdata), 32'h0000);
        bus.vga_req = 1'b0;

        // Lone CPU write 0x3000 <= 0xBEEF
        cyc(2);
        chk("wr_mem_we",    32'(bus.mem_we),    32'd1);
        chk("wr_mem_addr",  32'(bus.mem_addr),  32'h3000);
        chk("wr_mem_wdata", 32'(bus.mem_wdata), 32'hBEEF);
        cyc(1);
        chk("wr_mem_we_drop", 32'(bus.mem_we), 32'd0);
        cyc(1);
        chk("wr_cpu_ack",   32'(bus.cpu_ack),   32'd1);
        chk("wr_cpu_rdata", 32'(bus.cpu_rdata), 32'h0000);
        bus.cpu_we = 1'b0;

        // Back-to-back CPU read of 0x3000
        cyc(1);
        chk("rd_cpu_ack_idle", 32'(bus.cpu_ack), 32'd0);
        cyc(1);
        chk("rd_mem_we",   32'(bus.mem_we),   32'd0);
        chk("rd_mem_addr", 32'(bus.mem_addr), 32'h3000);
        cyc(2);
        chk("rd_cpu_ack",   32'(bus.cpu_ack),   32'd1);
        chk("rd_cpu_rdata", 32'(bus.cpu_rdata), 32'hBEEF);
        bus.cpu_req = 1'b0;

        // VGA read of preloaded 0x3050
        cyc(1);
        bus.vga_req  = 1'b1;
        bus.vga_addr = 16'h3050;
        cyc(3);
        chk("vr_vga_ack",   32'(bus.vga_ack),   32'd1);
        chk("vr_vga_rdata", 32'(bus.vga_rdata), 32'h4142);
        bus.vga_req  = 1'b0;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 16'h3000;
        cyc(4);
        chk("vr_cpu_ack",      32'(bus.cpu_ack),   32'd1);
        chk("vr_cpu_rdata",    32'(bus.cpu_rdata), 32'hBEEF);
        chk("vr_vga_rdata_hold", 32'(bus.vga_rdata), 32'h4142);
        chk("vr_vga_ack_low",  32'(bus.vga_ack),   32'd0);
        bus.cpu_req = 1'b0;

        // Continuous contention in active video: VGA, VGA, CPU (starved), VGA
        cyc(1);
        bus.vga_req = 1'b1;
        bus.cpu_req = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            vpat[k] = bus.vga_ack;
            cpat[k] = bus.cpu_ack;
            if (k == 7) chk("starve_cnt", 32'(dut.u_timer.wait_cnt_r), 32'd8);
        end
        chk("cont_vga_pattern", 32'(vpat), 32'h4044);
        chk("cont_cpu_pattern", 32'(cpat), 32'h0400);
        chk("cont_no_overlap",  32'(vpat & cpat), 32'h0);

        // Blanking: CPU first, VGA four cycles later
        bus.vga_active = 1'b0;
        cyc(3);
        chk("blank_cpu_ack", 32'(bus.cpu_ack), 32'd1);
        chk("blank_vga_ack", 32'(bus.vga_ack), 32'd0);
        bus.cpu_req = 1'b0;
        cyc(4);
        chk("blank_vga_ack2", 32'(bus.vga_ack), 32'd1);
        chk("blank_cpu_ack2", 32'(bus.cpu_ack), 32'd0);
        bus.vga_req    = 1'b0;
        bus.vga_active = 1'b1;

        // CPU write 0x3001 <= 0x5A5A, reset asserted during WAIT
        cyc(1);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 16'h3001;
        bus.cpu_wdata = 16'h5A5A;
        cyc(2);
        chk("mr_wait_we", 32'(bus.mem_we), 32'd0);
        reset = 1'b0;
        cyc(1);
        chk("mr_cpu_ack",   32'(bus.cpu_ack),   32'd0);
        chk("mr_mem_addr",  32'(bus.mem_addr),  32'h0);
        chk("mr_mem_wdata", 32'(bus.mem_wdata), 32'h0);
        chk("mr_mem_we",    32'(bus.mem_we),    32'd0);
        chk("mr_cpu_rdata", 32'(bus.cpu_rdata), 32'h0);
        chk("mr_vga_rdata", 32'(bus.vga_rdata), 32'h0);
        chk("mr_state",     32'(dut.state_r),   32'(ST_IDLE));
        chk("mr_ram_write", 32'(ram[8'h01]),    32'h5A5A);
        reset      = 1'b1;
        bus.cpu_we = 1'b0;
        cyc(2);
        chk("post_cpu_ack_wait", 32'(bus.cpu_ack), 32'd0);
        cyc(1);
        chk("post_cpu_ack",   32'(bus.cpu_ack),   32'd1);
        chk("post_cpu_rdata", 32'(bus.cpu_rdata), 32'h5A5A);
        bus.cpu_req = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
